jtframe_mist: RTL and testbench

JTFRAME_MIST -- requirements
Module: jtframe_mist

---
 rtl/jtframe_mist_pkg.sv | 46 ++++
 rtl/jtframe_mist_if.sv | 23 ++
 rtl/jtframe_mist_dwnld.sv | 81 ++++++++
 rtl/jtframe_mist.sv | 129 ++++++++++++
 tb/tb_jtframe_mist.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtframe_mist_pkg.sv
// Shared constants and types for the MiST frame glue: joystick/status bit indices,
// download state encoding and the programming-request record.
package jtframe_mist_pkg;

    localparam int JOY_R     = 0;
    localparam int JOY_L     = 1;
    localparam int JOY_D     = 2;
    localparam int JOY_U     = 3;
    localparam int JOY_B1    = 4;
    localparam int JOY_START = 11;
    localparam int JOY_COIN  = 12;
    localparam int JOY_PAUSE = 13;

    localparam int ST_RESET = 0;
    localparam int ST_FLIP  = 1;
    localparam int ST_VERT  = 2;
    localparam int ST_FX_LO = 6;
    localparam int ST_FX_HI = 7;
    localparam int ST_PSG   = 8;
    localparam int ST_FM    = 9;
    localparam int ST_TEST  = 10;

    typedef enum logic {
        DL_IDLE = 1'b0,
        DL_WAIT = 1'b1
    } dl_state_t;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } prog_req_t;

    localparam prog_req_t PROG_RST = '{addr: 22'd0, data: 8'd0, mask: 2'b11};

    // Active-high pad bits to active-low game bits; unused button slots read released.
    function automatic logic [9:0] joy_out(input logic [9:0] act, input int nbtn);
        logic [9:0] res;
        res = ~act;
        for (int i = 0; i < 10; i++) begin
            if (i > nbtn + 3) res[i] = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/jtframe_mist_if.sv
// ROM download stream in, SDRAM programming port out, plus the busy flag.
interface jtframe_mist_if;
    logic        downloading;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prog_rdy;
    logic        dwnld_busy;

    modport master (
        input  downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_rdy,
        output prog_addr, prog_data, prog_mask, prog_we, dwnld_busy
    );

    modport slave (
        output downloading, ioctl_addr, ioctl_data, ioctl_wr, prog_rdy,
        input  prog_addr, prog_data, prog_mask, prog_we, dwnld_busy
    );
endinterface

// File: rtl/jtframe_mist_dwnld.sv
// Download write path: one write in flight on prog_*, one more held in a skid entry,
// anything beyond that is dropped. prog_we rises 1 cycle after ioctl_wr, holds until prog_rdy.
module jtframe_mist_dwnld
    import jtframe_mist_pkg::*;
(
    input  logic           clk_sys,
    input  logic           rst,
    jtframe_mist_if.master dl
);

    dl_state_t state_q, state_d;
    prog_req_t cur_q, cur_d;
    prog_req_t buf_q, buf_d;
    logic      buf_vld_q, buf_vld_d;
    logic      busy_q, busy_d;
    logic      wr_ok;
    prog_req_t req_in;

    always_comb begin
        wr_ok       = dl.ioctl_wr && dl.downloading && (dl.ioctl_addr[24:22] == 3'd0);
        req_in.addr = dl.ioctl_addr[22:1];
        req_in.data = dl.ioctl_data;
        req_in.mask = dl.ioctl_addr[0] ? 2'b01 : 2'b10;

        state_d   = state_q;
        cur_d     = cur_q;
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;

        case (state_q)
            DL_IDLE: begin
                // A buffered write goes out first; a simultaneous new one refills the buffer.
                if (buf_vld_q) begin
                    cur_d     = buf_q;
                    state_d   = DL_WAIT;
                    buf_vld_d = 1'b0;
                    if (wr_ok) begin
                        buf_d     = req_in;
                        buf_vld_d = 1'b1;
                    end
                end else if (wr_ok) begin
                    cur_d   = req_in;
                    state_d = DL_WAIT;
                end
            end
            DL_WAIT: begin
                if (dl.prog_rdy) state_d = DL_IDLE;
                if (wr_ok && !buf_vld_q) begin
                    buf_d     = req_in;
                    buf_vld_d = 1'b1;
                end
            end
            default: state_d = DL_IDLE;
        endcase

        busy_d = dl.downloading || (state_d == DL_WAIT) || buf_vld_d;
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q   <= DL_IDLE;
            cur_q     <= PROG_RST;
            buf_q     <= PROG_RST;
            buf_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            buf_q     <= buf_d;
            buf_vld_q <= buf_vld_d;
            busy_q    <= busy_d;
        end
    end

    assign dl.prog_addr  = cur_q.addr;
    assign dl.prog_data  = cur_q.data;
    assign dl.prog_mask  = cur_q.mask;
    assign dl.prog_we    = (state_q == DL_WAIT);
    assign dl.dwnld_busy = busy_q;

endmodule

// File: rtl/jtframe_mist.sv
// MiST frame glue: pad remap, OSD dips, pause toggle, stretched game reset, ROM download.
// All outputs registered (1 cycle). JTFRAME_VERTICAL_EN adds direction rotation on status[2].
module jtframe_mist
    import jtframe_mist_pkg::*;
#(
    parameter int BUTTONS  = 2,
    parameter int RST_HOLD = 16
)(
    input  logic           clk_sys,
    input  logic           rst,
    input  logic [31:0]    status,
    input  logic           rst_req,
    input  logic [31:0]    joystick1,
    input  logic [31:0]    joystick2,
    output logic [9:0]     game_joystick1,
    output logic [9:0]     game_joystick2,
    output logic [3:0]     game_start,
    output logic [3:0]     game_coin,
    jtframe_mist_if.master dl,
    output logic           game_rst,
    output logic           LED,
    output logic           dip_flip,
    output logic           dip_test,
    output logic           dip_pause,
    output logic           enable_fm,
    output logic           enable_psg,
    output logic [1:0]     dip_fxlevel
);

    localparam int CW = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);

    logic [9:0]    gj1_q, gj1_d, gj2_q, gj2_d;
    logic [3:0]    start_q, start_d, coin_q, coin_d;
    logic          pause_q, pause_d;
    logic [1:0]    pz_q, pz_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          grst_q, grst_d;
    logic [9:0]    rot1, rot2;
    logic          rst_src;
    logic          unused_in;

`ifdef JTFRAME_VERTICAL_EN
    function automatic logic [9:0] vrot(input logic [9:0] j);
        logic [9:0] r;
        r        = j;
        r[JOY_R] = j[JOY_U];
        r[JOY_L] = j[JOY_D];
        r[JOY_D] = j[JOY_R];
        r[JOY_U] = j[JOY_L];
        return r;
    endfunction

    always_comb begin
        rot1 = joystick1[9:0];
        rot2 = joystick2[9:0];
        if (status[ST_VERT]) begin
            rot1 = vrot(joystick1[9:0]);
            rot2 = vrot(joystick2[9:0]);
        end
    end
`else
    assign rot1 = joystick1[9:0];
    assign rot2 = joystick2[9:0];
`endif

    always_comb begin
        gj1_d   = joy_out(rot1, BUTTONS);
        gj2_d   = joy_out(rot2, BUTTONS);
        start_d = {2'b11, ~joystick2[JOY_START], ~joystick1[JOY_START]};
        coin_d  = {2'b11, ~joystick2[JOY_COIN],  ~joystick1[JOY_COIN]};
        pz_d    = {joystick2[JOY_PAUSE], joystick1[JOY_PAUSE]};
        // Either pad rising is one event, so simultaneous presses give a single toggle.
        pause_d = pause_q ^ (|(pz_d & ~pz_q));

        rst_src = rst_req || status[ST_RESET] || dl.downloading;
        hold_d  = hold_q;
        if (rst_src)            hold_d = CW'(RST_HOLD);
        else if (hold_q != '0)  hold_d = hold_q - 1'b1;
        grst_d  = rst_src || (hold_q != '0);
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            gj1_q   <= '1;
            gj2_q   <= '1;
            start_q <= '1;
            coin_q  <= '1;
            pause_q <= 1'b1;
            pz_q    <= 2'b00;
            hold_q  <= CW'(RST_HOLD);
            grst_q  <= 1'b1;
        end else begin
            gj1_q   <= gj1_d;
            gj2_q   <= gj2_d;
            start_q <= start_d;
            coin_q  <= coin_d;
            pause_q <= pause_d;
            pz_q    <= pz_d;
            hold_q  <= hold_d;
            grst_q  <= grst_d;
        end
    end

    // OSD switches are plain retimed copies and need no reset value.
    always_ff @(posedge clk_sys) begin
        dip_flip    <= status[ST_FLIP];
        dip_test    <= ~status[ST_TEST];
        enable_psg  <= ~status[ST_PSG];
        enable_fm   <= ~status[ST_FM];
        dip_fxlevel <= status[ST_FX_HI:ST_FX_LO] ^ 2'b10;
    end

    jtframe_mist_dwnld u_dwnld (
        .clk_sys (clk_sys),
        .rst     (rst),
        .dl      (dl)
    );

    assign game_joystick1 = gj1_q;
    assign game_joystick2 = gj2_q;
    assign game_start     = start_q;
    assign game_coin      = coin_q;
    assign dip_pause      = pause_q;
    assign game_rst       = grst_q;
    assign LED            = dl.dwnld_busy;

    assign unused_in = ^{status, joystick1[31:14], joystick2[31:14], joystick1[10], joystick2[10]};

endmodule

// File: tb/tb_jtframe_mist.sv
// Bench for jtframe_mist: directed scenarios plus a randomized run, all checked
// against a behavioural model (pad mapping, toggle count, quiet-cycle count, write scoreboard).
module tb_jtframe_mist;

    localparam int BUTTONS  = 2;
    localparam int RST_HOLD = 16;

    logic        clk_sys = 1'b0;
    logic        rst, rst_req;
    logic [31:0] status, joystick1, joystick2;
    logic [9:0]  game_joystick1, game_joystick2;
    logic [3:0]  game_start, game_coin;
    logic        game_rst, LED, dip_flip, dip_test, dip_pause, enable_fm, enable_psg;
    logic [1:0]  dip_fxlevel;

    jtframe_mist_if dl_if ();

    jtframe_mist #(.BUTTONS(BUTTONS), .RST_HOLD(RST_HOLD)) dut (
        .clk_sys        (clk_sys),
        .rst            (rst),
        .status         (status),
        .rst_req        (rst_req),
        .joystick1      (joystick1),
        .joystick2      (joystick2),
        .game_joystick1 (game_joystick1),
        .game_joystick2 (game_joystick2),
        .game_start     (game_start),
        .game_coin      (game_coin),
        .dl             (dl_if),
        .game_rst       (game_rst),
        .LED            (LED),
        .dip_flip       (dip_flip),
        .dip_test       (dip_test),
        .dip_pause      (dip_pause),
        .enable_fm      (enable_fm),
        .enable_psg     (enable_psg),
        .dip_fxlevel    (dip_fxlevel)
    );

    always #5 clk_sys = ~clk_sys;

    int tests = 0;
    int fails = 0;

    // reference model state
    int          quiet = 0;
    int          toggles = 0;
    logic        p1 = 1'b0, p2 = 1'b0;
    logic [31:0] txq[$];
    int          outstanding = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] m_joy(input logic [31:0] j, input logic vert);
        logic [9:0] a;
        logic [9:0] hi;
        a = j[9:0];
`ifdef JTFRAME_VERTICAL_EN
        if (vert) begin
            a[0] = j[3];
            a[1] = j[2];
            a[2] = j[0];
            a[3] = j[1];
        end
`else
        if (vert) a = j[9:0];
`endif
        hi = '1;
        hi = hi << (BUTTONS + 4);
        return ~a | hi;
    endfunction

    function automatic logic [31:0] m_txn(input logic [24:0] a, input logic [7:0] d);
        logic [1:0] m;
        m = a[0] ? 2'b01 : 2'b10;
        return {m, d, a[22:1]};
    endfunction

    // Advance one clk_sys edge and check every output against the model.
    task automatic step();
        logic [31:0] cj1, cj2, cst;
        logic [24:0] ca;
        logic [7:0]  cd;
        logic        crst, crr, cdld, cwr, crdy, pwe;
        cj1 = joystick1; cj2 = joystick2; cst = status;
        crst = rst; crr = rst_req;
        cdld = dl_if.downloading; cwr = dl_if.ioctl_wr; crdy = dl_if.prog_rdy;
        ca = dl_if.ioctl_addr; cd = dl_if.ioctl_data;
        pwe = dl_if.prog_we;
        @(posedge clk_sys);
        #1;
        chk("dip_flip", 32'(dip_flip), 32'(cst[1]));
        chk("dip_test", 32'(dip_test), 32'(!cst[10]));
        chk("enable_psg", 32'(enable_psg), 32'(!cst[8]));
        chk("enable_fm", 32'(enable_fm), 32'(!cst[9]));
        chk("dip_fxlevel", 32'(dip_fxlevel), 32'(cst[7:6] ^ 2'b10));
        if (crst) begin
            toggles = 0; p1 = 1'b0; p2 = 1'b0; quiet = 0;
            txq.delete(); outstanding = 0;
            chk("rst_joy1", 32'(game_joystick1), 32'h3FF);
            chk("rst_joy2", 32'(game_joystick2), 32'h3FF);
            chk("rst_start", 32'(game_start), 32'hF);
            chk("rst_coin", 32'(game_coin), 32'hF);
            chk("rst_pause", 32'(dip_pause), 32'd1);
            chk("rst_game_rst", 32'(game_rst), 32'd1);
            chk("rst_prog_we", 32'(dl_if.prog_we), 32'd0);
            chk("rst_busy", 32'(dl_if.dwnld_busy), 32'd0);
            chk("rst_prog", {dl_if.prog_mask, dl_if.prog_data, dl_if.prog_addr}, 32'hC000_0000);
        end else begin
            chk("joy1", 32'(game_joystick1), 32'(m_joy(cj1, cst[2])));
            chk("joy2", 32'(game_joystick2), 32'(m_joy(cj2, cst[2])));
            chk("start", 32'(game_start), 32'({2'b11, !cj2[11], !cj1[11]}));
            chk("coin", 32'(game_coin), 32'({2'b11, !cj2[12], !cj1[12]}));
            if ((cj1[13] && !p1) || (cj2[13] && !p2)) toggles++;
            p1 = cj1[13]; p2 = cj2[13];
            chk("dip_pause", 32'(dip_pause), 32'(toggles % 2 == 0));
            if (crr || cst[0] || cdld) quiet = 0;
            else if (quiet < 1000) quiet++;
            chk("game_rst", 32'(game_rst), 32'(quiet <= RST_HOLD));
            // at most one write on the port plus one waiting; the rest are lost
            if (cwr && cdld && ca[24:22] == 3'd0 && outstanding < 2) begin
                txq.push_back(m_txn(ca, cd));
                outstanding++;
            end
            if (pwe && crdy) outstanding--;
            chk("dwnld_busy", 32'(dl_if.dwnld_busy), 32'(cdld || outstanding > 0));
            chk("LED", 32'(LED), 32'(cdld || outstanding > 0));
            if (!pwe && dl_if.prog_we) begin
                chk("issue_expected", 32'(txq.size() > 0), 32'd1);
                if (txq.size() > 0) begin
                    chk("issue_txn", {dl_if.prog_mask, dl_if.prog_data, dl_if.prog_addr}, txq[0]);
                    void'(txq.pop_front());
                end
            end
        end
    endtask

    task automatic wr(input logic [24:0] a, input logic [7:0] d);
        dl_if.ioctl_wr   = 1'b1;
        dl_if.ioctl_addr = a;
        dl_if.ioctl_data = d;
    endtask

    initial begin
        int n;
        rst = 1'b1; rst_req = 1'b0; status = '0; joystick1 = '0; joystick2 = '0;
        dl_if.downloading = 1'b0; dl_if.ioctl_addr = '0; dl_if.ioctl_data = '0;
        dl_if.ioctl_wr = 1'b0; dl_if.prog_rdy = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // pad mapping: R, U, button 1
        joystick1 = 32'h0000_0019;
        step();
        chk("joy1_r_u_b1", 32'(game_joystick1), 32'h3E6);
        joystick1 = 32'h0000_1800; joystick2 = 32'h0000_1000;
        step();
        chk("start_p1", 32'(game_start), 32'hE);
        chk("coin_both", 32'(game_coin), 32'hC);

        // fx level and pause toggling
        joystick1 = '0; joystick2 = '0; status = 32'h0000_0040;
        step();
        chk("fxlevel_01", 32'(dip_fxlevel), 32'h3);
        joystick2[13] = 1'b1; step();
        chk("pause_first", 32'(dip_pause), 32'd0);
        joystick2[13] = 1'b0; step();
        joystick2[13] = 1'b1; step();
        chk("pause_second", 32'(dip_pause), 32'd1);
        joystick2[13] = 1'b0; step();
        joystick1[13] = 1'b1; joystick2[13] = 1'b1; step();
        chk("pause_both_once", 32'(dip_pause), 32'd0);
        joystick1 = '0; joystick2 = '0;
        repeat (20) step();

        // reset stretch after a one-cycle request
        chk("game_rst_idle", 32'(game_rst), 32'd0);
        n = 0;
        rst_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            rst_req = 1'b0;
            if (game_rst) n++;
            else break;
        end
        chk("rst_req_len", 32'(n), 32'(1 + RST_HOLD));

        // single write, ack after three waiting cycles
        dl_if.downloading = 1'b1;
        wr(25'h3, 8'hA5);
        step();
        dl_if.ioctl_wr = 1'b0;
        chk("w1_we", 32'(dl_if.prog_we), 32'd1);
        chk("w1_addr", 32'(dl_if.prog_addr), 32'h1);
        chk("w1_mask", 32'(dl_if.prog_mask), 32'h1);
        chk("w1_data", 32'(dl_if.prog_data), 32'hA5);
        n = 1;
        for (int i = 0; i < 10; i++) begin
            dl_if.prog_rdy = (n == 4);
            step();
            if (dl_if.prog_we) n++;
            else break;
        end
        dl_if.prog_rdy = 1'b0;
        chk("w1_we_cycles", 32'(n), 32'd4);

        // back-to-back writes: second buffered, third dropped
        wr(25'h100, 8'h11); step();
        chk("b2b_first_addr", 32'(dl_if.prog_addr), 32'h80);
        wr(25'h201, 8'h22); step();
        wr(25'h302, 8'h33); step();
        dl_if.ioctl_wr = 1'b0;
        repeat (2) step();
        dl_if.prog_rdy = 1'b1; step();
        dl_if.prog_rdy = 1'b0;
        chk("b2b_gap", 32'(dl_if.prog_we), 32'd0);
        step();
        chk("b2b_second_we", 32'(dl_if.prog_we), 32'd1);
        chk("b2b_second_addr", 32'(dl_if.prog_addr), 32'h100);
        chk("b2b_second_data", 32'(dl_if.prog_data), 32'h22);
        dl_if.prog_rdy = 1'b1; step();
        dl_if.prog_rdy = 1'b0;
        repeat (4) step();
        chk("b2b_third_dropped", 32'(dl_if.prog_we), 32'd0);

        // ignored writes: not downloading, address out of range
        dl_if.downloading = 1'b0; wr(25'h10, 8'h44); step();
        dl_if.downloading = 1'b1; wr(25'h040_0000, 8'h55); step();
        dl_if.ioctl_wr = 1'b0; step();
        chk("ignored_we", 32'(dl_if.prog_we), 32'd0);
        dl_if.downloading = 1'b0;
        repeat (2) step();
        chk("busy_clear", 32'(dl_if.dwnld_busy), 32'd0);

        // reset aborts a pending write
        dl_if.downloading = 1'b1; wr(25'h5, 8'h66); step();
        dl_if.ioctl_wr = 1'b0;
        chk("abort_pending", 32'(dl_if.prog_we), 32'd1);
        rst = 1'b1; step();
        rst = 1'b0; dl_if.downloading = 1'b0;
        repeat (5) step();
        chk("abort_no_reissue", 32'(dl_if.prog_we), 32'd0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [24:0] a;
            joystick1 = $urandom; joystick2 = $urandom;
            status = $urandom;
            if ($urandom_range(0, 15) != 0) status[0] = 1'b0;
            rst_req = ($urandom_range(0, 63) == 0);
            dl_if.downloading = ($urandom_range(0, 9) != 0);
            a = 25'($urandom);
            if ($urandom_range(0, 7) != 0) a[24:22] = 3'd0;
            dl_if.ioctl_addr = a;
            dl_if.ioctl_data = 8'($urandom);
            dl_if.ioctl_wr = $urandom_range(0, 1) == 1;
            dl_if.prog_rdy = ($urandom_range(0, 9) < 4);
            step();
        end

        // drain
        dl_if.ioctl_wr = 1'b0; dl_if.downloading = 1'b0; dl_if.prog_rdy = 1'b1;
        rst_req = 1'b0; status = '0;
        repeat (10) step();
        chk("drain_queue", 32'(txq.size()), 32'd0);
        chk("drain_we", 32'(dl_if.prog_we), 32'd0);
        chk("drain_busy", 32'(dl_if.dwnld_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
